button_debouncer_multi: RTL

- Parametrised N-channel push-button debouncer for the ULX3S menu/UI logic.
- Inputs: raw, asynchronous, glitchy button pins.
- Outputs, per channel, all synchronous to clk:
  - a clean level
  - a one-cycle press pulse
  - a one-cycle release pulse
  - optionally, an auto-repeat pulse for held buttons
- Replaces per-button debouncer instances with one vectored block with configurable polarity and filter length.

---
 rtl/button_debouncer_multi.sv | 120 ++++++++++++
 1 files changed

// File: rtl/button_debouncer_multi.sv
// button_debouncer_multi: N-channel push-button debouncer with selectable pin
// polarity and a 2^CNT_BITS-cycle stability filter. Each channel provides a
// clean level plus one-cycle press/release pulses.
// Optional auto-repeat on held buttons: define BTN_AUTOREPEAT_EN.
module button_debouncer_multi #(
  parameter int N            = 7,
  parameter int CNT_BITS     = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_down,
  output logic [N-1:0] btn_up,
  output logic [N-1:0] btn_repeat,
  output logic         any_down
);

  // Elaboration-time guard on the repeat timing range.
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 16777215 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 16777215) begin : g_param_check
    $error("button_debouncer_multi: repeat timing out of range");
  end

  localparam logic [N-1:0] POL = {N{ACTIVE_LOW}};

  logic [N-1:0]          sync0;
  logic [N-1:0]          sync1;
  logic [CNT_BITS-1:0]   cnt [N];
  logic [N-1:0]          idle;
  logic [N-1:0]          cnt_max;
  logic [N-1:0]          accept;

  // Two-flop synchroniser; polarity is normalised so 1 always means pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btn ^ POL;
      sync1 <= sync0;
    end
  end

  // Per-channel idle / terminal-count decode.
  always_comb begin
    idle    = '0;
    cnt_max = '0;
    for (int i = 0; i < N; i++) begin
      idle[i]    = (btn_state[i] == sync1[i]);
      cnt_max[i] = &cnt[i];
    end
  end

  assign accept = ~idle & cnt_max;

  // Stability counters and debounced level; any return to idle drops the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_state <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      btn_state <= btn_state ^ accept;
      for (int i = 0; i < N; i++) begin
        if (idle[i]) cnt[i] <= '0;
        else         cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign btn_down = {N{~reset}} & accept & ~btn_state;
  assign btn_up   = {N{~reset}} & accept & btn_state;
  assign any_down = |btn_down;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [23:0] DELAY_M1 = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RATE_M1  = 24'(REPEAT_RATE - 1);

  logic [23:0]  rcnt [N];
  logic [N-1:0] first;
  logic [N-1:0] rep_hit;

  // Repeat is due when the held button reaches the current phase's interval.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N; i++) begin
      rep_hit[i] = btn_state[i] && (rcnt[i] == (first[i] ? DELAY_M1 : RATE_M1));
    end
  end

  // A release landing on a due repeat wins over that repeat.
  assign btn_repeat = {N{~reset}} & rep_hit & ~btn_up;

  // Repeat interval counters; restart on press, clear on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      first <= '1;
      for (int i = 0; i < N; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (btn_down[i] || btn_up[i] || !btn_state[i]) begin
          rcnt[i]  <= '0;
          first[i] <= 1'b1;
        end else if (rep_hit[i]) begin
          rcnt[i]  <= '0;
          first[i] <= 1'b0;
        end else begin
          rcnt[i]  <= rcnt[i] + 24'd1;
        end
      end
    end
  end
`else
  assign btn_repeat = '0;
`endif

endmodule
